// File: rtl/aes_ctrl_pkg.sv
// Shared control definitions for the iterative AES round datapath, its key-expansion
// unit and the sequencer that drives both.
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] KEYLEN_128  = 2'd0;
  localparam logic [1:0] KEYLEN_192  = 2'd1;
  localparam logic [1:0] KEYLEN_256  = 2'd2;
  localparam logic [1:0] KEYLEN_RSVD = 2'd3;

  localparam int RND_IDX_W = 4;

  // Reserved keylen never reaches the datapath; it maps to 10 only to keep the decode total.
  function automatic logic [RND_IDX_W-1:0] nr_of(input logic [1:0] keylen);
    case (keylen)
      KEYLEN_192: nr_of = 4'd12;
      KEYLEN_256: nr_of = 4'd14;
      default:    nr_of = 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round-key index counter: loadable, steps up or down, flags when it sits on term_val.
module aes_round_counter
  import aes_ctrl_pkg::*;
#(
  parameter int W = RND_IDX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         down,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (step) begin
      count <= down ? count - W'(1) : count + W'(1);
    end
  end

  assign tc = (count == term_val);

endmodule

// File: rtl/aes_round_sequencer.sv
// Job sequencer for a shared AES round/key-expansion datapath: accepts one job,
// runs key expansion when the cached schedule cannot be reused, then steps the rounds.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int KX_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_decrypt,
  input  logic [1:0]           req_keylen,
  input  logic                 req_same_key,
  output logic                 kx_start,
  input  logic                 kx_done,
  output logic                 rnd_load,
  output logic                 rnd_step,
  output logic                 rnd_final,
  output logic                 rnd_decrypt,
  output logic [RND_IDX_W-1:0] rnd_idx,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic                 busy,
  output logic                 err,
  output state_t               fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid is never withdrawn by this block before ready, and ready never depends on valid.

  localparam int WAIT_W = (KX_TIMEOUT > 2) ? $clog2(KX_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(KX_TIMEOUT - 1);

  state_t                 state;
  logic                   key_valid;
  logic [1:0]             cached_keylen;
  logic [1:0]             keylen_q;
  logic [RND_IDX_W-1:0]   nr_q;
  logic [WAIT_W-1:0]      wait_cnt;

  logic                   accept;
  logic                   rsvd;
  logic                   hit;
  logic                   kx_ok;
  logic                   cnt_load;
  logic                   cnt_step;
  logic                   cnt_tc;
  logic [RND_IDX_W-1:0]   cnt_val;
  logic [RND_IDX_W-1:0]   term_val;

  assign accept = (state == ST_IDLE) && req_valid;
  assign rsvd   = (req_keylen == KEYLEN_RSVD);
  assign hit    = req_same_key && key_valid && (req_keylen == cached_keylen);
  assign kx_ok  = (state == ST_KEYEXP) && kx_done;

  // The index is preloaded on the transition into INIT so it is valid with rnd_load.
  always_comb begin
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    cnt_val  = '0;
    if (accept && !rsvd && hit) begin
      cnt_load = 1'b1;
      cnt_val  = req_decrypt ? nr_of(req_keylen) : '0;
    end else if (kx_ok) begin
      cnt_load = 1'b1;
      cnt_val  = rnd_decrypt ? nr_q : '0;
    end else if (state == ST_FINAL) begin
      cnt_load = 1'b1;
    end else if ((state == ST_INIT) || (state == ST_ROUND)) begin
      cnt_step = 1'b1;
    end
  end

  // Last full round: Nr-1 going up, 1 going down.
  assign term_val = rnd_decrypt ? RND_IDX_W'(1) : nr_q - RND_IDX_W'(1);

  aes_round_counter #(.W(RND_IDX_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .step     (cnt_step),
    .down     (rnd_decrypt),
    .term_val (term_val),
    .count    (rnd_idx),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      key_valid     <= 1'b0;
      cached_keylen <= KEYLEN_128;
      keylen_q      <= KEYLEN_128;
      nr_q          <= '0;
      wait_cnt      <= '0;
      kx_start      <= 1'b0;
      rnd_load      <= 1'b0;
      rnd_step      <= 1'b0;
      rnd_final     <= 1'b0;
      rnd_decrypt   <= 1'b0;
      done_valid    <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      kx_start <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            keylen_q <= req_keylen;
            nr_q     <= nr_of(req_keylen);
            if (rsvd) begin
              err <= 1'b1;
            end else begin
              rnd_decrypt <= req_decrypt;
              busy        <= 1'b1;
              if (hit) begin
                state    <= ST_INIT;
                rnd_load <= 1'b1;
              end else begin
                state     <= ST_KEYEXP;
                kx_start  <= 1'b1;
                key_valid <= 1'b0;
                wait_cnt  <= '0;
              end
            end
          end
        end
        ST_KEYEXP: begin
          // kx_done is checked first so it beats a timeout in the same cycle.
          if (kx_done) begin
            key_valid     <= 1'b1;
            cached_keylen <= keylen_q;
            state         <= ST_INIT;
            rnd_load      <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            err         <= 1'b1;
            state       <= ST_IDLE;
            busy        <= 1'b0;
            rnd_decrypt <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_INIT: begin
          state    <= ST_ROUND;
          rnd_load <= 1'b0;
          rnd_step <= 1'b1;
        end
        ST_ROUND: begin
          if (cnt_tc) begin
            state     <= ST_FINAL;
            rnd_final <= 1'b1;
          end
        end
        ST_FINAL: begin
          state      <= ST_DONE;
          rnd_step   <= 1'b0;
          rnd_final  <= 1'b0;
          done_valid <= 1'b1;
        end
        ST_DONE: begin
          if (done_ready) begin
            state       <= ST_IDLE;
            done_valid  <= 1'b0;
            busy        <= 1'b0;
            rnd_decrypt <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign fsm_state = state;

endmodule
